sram_like_bridge: RTL and testbench

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

---
 rtl/sram_like_bridge.sv | 129 ++++++++++++
 tb/tb_sram_like_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_bridge.sv
// CPU-to-SRAM-like bus bridge. Accepts one CPU access at a time, converts byte
// enables into size/address, tracks cancelled accesses whose responses are
// still outstanding and silently drops those responses.
module sram_like_bridge #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DISC_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          cpu_en,
  input  logic [3:0]    cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          stall,
  output logic          err,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [DISC_W-1:0] DiscMax = '1;

  state_e              state_q, state_d;
  logic [DISC_W-1:0]   disc_cnt_q, disc_cnt_d;
  logic [31:0]         rdata_q;
  logic                bus_wr_q;
  logic [1:0]          bus_size_q;
  logic [AW-1:0]       bus_addr_q;
  logic [31:0]         bus_wdata_q;

  logic                wen_legal;
  logic [1:0]          dec_size;
  logic [1:0]          dec_lo;
  logic                issue;
  logic                completion;
  logic                disc_inc;
  logic                disc_dec;

  // Byte-enable pattern to transfer size and low address bits.
  always_comb begin
    wen_legal = 1'b1;
    dec_size  = 2'd2;
    dec_lo    = 2'b00;
    case (cpu_wen)
      4'b0000: begin dec_size = 2'd2; dec_lo = 2'b00; end
      4'b0001: begin dec_size = 2'd0; dec_lo = 2'b00; end
      4'b0010: begin dec_size = 2'd0; dec_lo = 2'b01; end
      4'b0100: begin dec_size = 2'd0; dec_lo = 2'b10; end
      4'b1000: begin dec_size = 2'd0; dec_lo = 2'b11; end
      4'b0011: begin dec_size = 2'd1; dec_lo = 2'b00; end
      4'b1100: begin dec_size = 2'd1; dec_lo = 2'b10; end
      4'b1111: begin dec_size = 2'd2; dec_lo = 2'b00; end
      default: wen_legal = 1'b0;
    endcase
  end

  // Next-state, discard accounting and CPU-facing outputs.
  always_comb begin
    state_d    = state_q;
    disc_cnt_d = disc_cnt_q;

    // A response only belongs to the live access once every discarded one has drained.
    completion = ~reset & (state_q == StWait) & bus_data_ok & (disc_cnt_q == '0);
    issue      = (state_q == StIdle) & cpu_en & ~flush & wen_legal & (disc_cnt_q != DiscMax);
    err        = ~reset & (state_q == StIdle) & cpu_en & ~wen_legal;
    disc_inc   = ((state_q == StReq) & flush & bus_addr_ok) |
                 ((state_q == StWait) & flush & ~completion);
    disc_dec   = bus_data_ok & (disc_cnt_q != '0);

    unique case (state_q)
      StIdle: if (issue) state_d = StReq;
      StReq: begin
        if (flush)            state_d = StIdle;
        else if (bus_addr_ok) state_d = StWait;
      end
      StWait: begin
        if (completion || flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    case ({disc_inc, disc_dec})
      2'b10:   disc_cnt_d = disc_cnt_q + DISC_W'(1);
      2'b01:   disc_cnt_d = disc_cnt_q - DISC_W'(1);
      default: disc_cnt_d = disc_cnt_q;
    endcase

    bus_req   = ~reset & (state_q == StReq);
    stall     = ~reset & cpu_en & ~flush & ~completion & ~err;
    cpu_rdata = completion ? bus_rdata : rdata_q;
    bus_wr    = bus_wr_q;
    bus_size  = bus_size_q;
    bus_addr  = bus_addr_q;
    bus_wdata = bus_wdata_q;
  end

  // State, discard counter, latched request fields and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      disc_cnt_q  <= '0;
      rdata_q     <= '0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      disc_cnt_q <= disc_cnt_d;
      if (completion) rdata_q <= bus_rdata;
      if (issue) begin
        bus_wr_q    <= (cpu_wen != 4'b0000);
        bus_size_q  <= dec_size;
        bus_addr_q  <= {cpu_addr[AW-1:2], dec_lo};
        bus_wdata_q <= cpu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: reset, read, byte write, half write with
// cancel, illegal enables, discard of stale responses, saturation, reset mid-access.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        reset, flush, cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, err, bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  int checks = 0;
  int errors = 0;

  sram_like_bridge #(.AW(32), .DISC_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .stall       (stall),
    .err         (err),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; cpu_en = 1'b1; cpu_wen = 4'h0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; bus_rdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    // Reset values, with cpu_en held high to show stall is masked.
    repeat (2) tick();
    settle();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("rst_bus_size", {30'd0, bus_size}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick();
    reset = 1'b0; cpu_en = 1'b0;

    // Word read: bus_req in cycles 1-2, addr_ok at 2, data_ok at 4.
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1000_0004;
    settle();
    chk("rd_c0_stall", {31'd0, stall}, 32'd1);
    chk("rd_c0_req", {31'd0, bus_req}, 32'd0);
    tick();
    settle();
    chk("rd_c1_req", {31'd0, bus_req}, 32'd1);
    chk("rd_c1_addr", bus_addr, 32'h1000_0004);
    chk("rd_c1_size", {30'd0, bus_size}, 32'd2);
    chk("rd_c1_wr", {31'd0, bus_wr}, 32'd0);
    chk("rd_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("rd_c2_req", {31'd0, bus_req}, 32'd1);
    chk("rd_c2_addr", bus_addr, 32'h1000_0004);
    tick();
    bus_addr_ok = 1'b0;
    settle();
    chk("rd_c3_req", {31'd0, bus_req}, 32'd0);
    chk("rd_c3_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rd_c4_stall", {31'd0, stall}, 32'd0);
    chk("rd_c4_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0; cpu_en = 1'b0;
    settle();
    chk("rd_hold_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_idle_req", {31'd0, bus_req}, 32'd0);

    // Byte write to lane 2.
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_wdata = 32'h00AB_0000; cpu_addr = 32'h20;
    settle();
    chk("wb_c0_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("wb_req", {31'd0, bus_req}, 32'd1);
    chk("wb_wr", {31'd0, bus_wr}, 32'd1);
    chk("wb_size", {30'd0, bus_size}, 32'd0);
    chk("wb_addr", bus_addr, 32'h22);
    chk("wb_wdata", bus_wdata, 32'h00AB_0000);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    settle();
    chk("wb_done_stall", {31'd0, stall}, 32'd0);
    chk("wb_done_rdata", cpu_rdata, 32'h1234_5678);
    tick();
    cpu_en = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    settle();
    chk("wb_idle_req", {31'd0, bus_req}, 32'd0);
    chk("wb_hold_rdata", cpu_rdata, 32'h1234_5678);

    // Upper-half write, cancelled in REQ before addr_ok: no discard.
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b1100; cpu_addr = 32'h40;
    tick();
    settle();
    chk("wh_req", {31'd0, bus_req}, 32'd1);
    chk("wh_size", {30'd0, bus_size}, 32'd1);
    chk("wh_addr", bus_addr, 32'h42);
    tick();
    flush = 1'b1;
    settle();
    chk("fr_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0; cpu_en = 1'b0;
    settle();
    chk("fr_idle_req", {31'd0, bus_req}, 32'd0);
    chk("fr_disc", 32'(dut.disc_cnt_q), 32'd0);

    // Illegal byte enables.
    tick();
    cpu_en = 1'b1; cpu_wen = 4'b0101; cpu_addr = 32'h80;
    settle();
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_stall", {31'd0, stall}, 32'd0);
    chk("ill_req", {31'd0, bus_req}, 32'd0);
    tick();
    cpu_en = 1'b0; cpu_wen = 4'b0000;
    settle();
    chk("ill_err_gone", {31'd0, err}, 32'd0);
    chk("ill_no_req", {31'd0, bus_req}, 32'd0);

    // Flush in WAIT, then a fresh read whose first response is stale.
    tick();
    cpu_en = 1'b1; cpu_addr = 32'h100;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; flush = 1'b1;
    settle();
    chk("fw_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0; cpu_addr = 32'h200;
    settle();
    chk("fw_disc", 32'(dut.disc_cnt_q), 32'd1);
    chk("fw_new_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("fw_new_req", {31'd0, bus_req}, 32'd1);
    chk("fw_new_addr", bus_addr, 32'h200);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    settle();
    chk("fw_stale_stall", {31'd0, stall}, 32'd1);
    chk("fw_stale_rdata", cpu_rdata, 32'h1234_5678);
    tick();
    bus_rdata = 32'h2222_2222;
    settle();
    chk("fw_live_disc", 32'(dut.disc_cnt_q), 32'd0);
    chk("fw_live_stall", {31'd0, stall}, 32'd0);
    chk("fw_live_rdata", cpu_rdata, 32'h2222_2222);
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0; cpu_en = 1'b0;
    settle();
    chk("fw_hold_rdata", cpu_rdata, 32'h2222_2222);

    // Three cancels after addr_ok saturate the 2-bit discard counter.
    for (int i = 0; i < 3; i++) begin
      tick();
      cpu_en = 1'b1; cpu_addr = 32'h400 + 32'(i * 4);
      tick();
      bus_addr_ok = 1'b1; flush = 1'b1;
      tick();
      bus_addr_ok = 1'b0; flush = 1'b0; cpu_en = 1'b0;
    end
    cpu_en = 1'b1; cpu_addr = 32'h500;
    settle();
    chk("sat_disc", 32'(dut.disc_cnt_q), 32'd3);
    chk("sat_stall", {31'd0, stall}, 32'd1);
    tick();
    settle();
    chk("sat_no_req", {31'd0, bus_req}, 32'd0);
    chk("sat_stall2", {31'd0, stall}, 32'd1);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    settle();
    chk("sat_drain_stall", {31'd0, stall}, 32'd1);
    chk("sat_drain_rdata", cpu_rdata, 32'h2222_2222);
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("sat_disc2", 32'(dut.disc_cnt_q), 32'd2);
    chk("sat_req_low", {31'd0, bus_req}, 32'd0);
    tick();
    bus_addr_ok = 1'b1;
    settle();
    chk("sat_req", {31'd0, bus_req}, 32'd1);
    chk("sat_addr", bus_addr, 32'h500);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_AAAA;
    settle();
    chk("sat_d1_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_rdata = 32'hBBBB_BBBB;
    settle();
    chk("sat_d2_stall", {31'd0, stall}, 32'd1);
    chk("sat_d2_rdata", cpu_rdata, 32'h2222_2222);
    tick();
    bus_rdata = 32'hCCCC_CCCC;
    settle();
    chk("sat_d3_stall", {31'd0, stall}, 32'd0);
    chk("sat_d3_rdata", cpu_rdata, 32'hCCCC_CCCC);
    tick();
    bus_data_ok = 1'b0; cpu_en = 1'b0;

    // Reset while waiting on data: access abandoned, late response ignored.
    tick();
    cpu_en = 1'b1; cpu_addr = 32'h300;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; reset = 1'b1;
    settle();
    chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_req", {31'd0, bus_req}, 32'd0);
    tick();
    reset = 1'b0; cpu_en = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999;
    settle();
    chk("rw_rdata", cpu_rdata, 32'd0);
    chk("rw_disc", 32'(dut.disc_cnt_q), 32'd0);
    tick();
    bus_data_ok = 1'b0;
    settle();
    chk("rw_rdata2", cpu_rdata, 32'd0);
    chk("rw_disc2", 32'(dut.disc_cnt_q), 32'd0);
    chk("rw_idle_req", {31'd0, bus_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
